// File: rtl/im_loader_pkg.sv
// Shared constants, FSM encoding and helpers for the instruction-memory loader.
package im_loader_pkg;

    localparam int IM_ADDR_W    = 5;
    localparam int IM_DATA_W    = 32;
    localparam int IM_MAX_WORDS = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic words_legal(input int unsigned n);
        return (n != 0) && (n <= IM_MAX_WORDS);
    endfunction

endpackage

// File: rtl/im_loader_if.sv
// Byte-stream input, instruction-memory write port and status lines of the loader.
interface im_loader_if
    import im_loader_pkg::*;
#(
    parameter int ADDR_W = IM_ADDR_W,
    parameter int DATA_W = IM_DATA_W
) ();

    logic              start;
    logic [ADDR_W:0]   num_words;
    logic [7:0]        in_byte;
    logic              in_valid;
    logic              in_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              cpu_stall;
    logic              done;
    logic              error;

    modport master (
        output start, num_words, in_byte, in_valid,
        input  in_ready, we, waddr, wdata, cpu_stall, done, error
    );

    modport slave (
        input  start, num_words, in_byte, in_valid,
        output in_ready, we, waddr, wdata, cpu_stall, done, error
    );

endinterface

// File: rtl/im_loader.sv
// Assembles a little-endian byte stream into instruction words and writes them
// to consecutive memory addresses while stalling the core.
module im_loader
    import im_loader_pkg::*;
#(
    parameter int ADDR_W = IM_ADDR_W,
    parameter int DATA_W = IM_DATA_W
) (
    input  logic        clk,
    input  logic        rst,
    im_loader_if.slave  bus
);

    localparam int LANES  = DATA_W / 8;
    localparam int LANE_W = $clog2(LANES);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic [ADDR_W:0]   num_words_q, num_words_d;
    logic [LANE_W-1:0] byte_idx_q, byte_idx_d;
    logic [DATA_W-1:0] asm_q, asm_d;
    logic              in_ready_q, in_ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              cpu_stall_q, cpu_stall_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              xfer;

    // in_ready_q is high exactly while in LOAD, so it doubles as the state qualifier
    assign xfer = in_ready_q & bus.in_valid;

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        num_words_d = num_words_q;
        byte_idx_d  = byte_idx_q;
        asm_d       = asm_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        we_d        = 1'b0;
        done_d      = 1'b0;
        error_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (words_legal(32'(bus.num_words))) begin
                        state_d     = ST_LOAD;
                        num_words_d = bus.num_words;
                        word_cnt_d  = '0;
                        byte_idx_d  = '0;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    asm_d[{byte_idx_q, 3'b000} +: 8] = bus.in_byte;
                    byte_idx_d = byte_idx_q + 1'b1;
                    if (byte_idx_q == LAST_LANE) begin
                        state_d = ST_WRITE;
                        we_d    = 1'b1;
                        waddr_d = word_cnt_q[ADDR_W-1:0];
                        wdata_d = asm_d;
                    end
                end
            end
            ST_WRITE: begin
                word_cnt_d = word_cnt_q + 1'b1;
                byte_idx_d = '0;
                if (word_cnt_d == num_words_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are registered from the next state so they line up with it
        in_ready_d  = (state_d == ST_LOAD);
        cpu_stall_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            word_cnt_q  <= '0;
            num_words_q <= '0;
            byte_idx_q  <= '0;
            asm_q       <= '0;
            in_ready_q  <= 1'b0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            cpu_stall_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            num_words_q <= num_words_d;
            byte_idx_q  <= byte_idx_d;
            asm_q       <= asm_d;
            in_ready_q  <= in_ready_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            cpu_stall_q <= cpu_stall_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.we        = we_q;
    assign bus.waddr     = waddr_q;
    assign bus.wdata     = wdata_q;
    assign bus.cpu_stall = cpu_stall_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;

endmodule

// File: tb/tb_im_loader.sv
// Randomized self-checking bench for im_loader: word i of a load must land at
// address i with the four streamed bytes packed little-endian.
module tb_im_loader;
    import im_loader_pkg::*;

    localparam int AW = 5;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    im_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    im_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    // Monitor state, written only by the monitor processes
    int cyc = 0;
    logic [AW-1:0] got_addr[$];
    logic [DW-1:0] got_data[$];
    logic [DW-1:0] shadow[0:31];
    int done_cnt = 0, err_cnt = 0, lat_bad = 0, xfer_cnt = 0;
    int we_cyc_last = 0, done_cyc_last = 0;
    bit pend_we = 1'b0;

    logic [DW-1:0] stim[0:31];
    int stall_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // A write must appear exactly one cycle after every 4th accepted byte
    always @(negedge clk) begin
        if (rst) begin
            pend_we  = 1'b0;
            xfer_cnt = 0;
        end else begin
            if (bus.we !== pend_we) lat_bad++;
            if (bus.we === 1'b1) begin
                got_addr.push_back(bus.waddr);
                got_data.push_back(bus.wdata);
                shadow[bus.waddr] = bus.wdata;
                we_cyc_last = cyc;
            end
            if (bus.done === 1'b1) begin
                done_cnt++;
                done_cyc_last = cyc;
            end
            if (bus.error === 1'b1) err_cnt++;
            pend_we = 1'b0;
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
                pend_we = (xfer_cnt % 4 == 3);
                xfer_cnt++;
            end
        end
    end

    task automatic pulse_start(input int n);
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.num_words = n[AW:0];
        @(posedge clk); #1;
        bus.start     = 1'b0;
    endtask

    task automatic send_bytes(input int n, input int gap_pct, input int max_bytes, output int sent);
        int t;
        sent = 0;
        for (int w = 0; w < n; w++) begin
            for (int b = 0; b < 4; b++) begin
                if (sent == max_bytes) return;
                while ($urandom_range(99) < gap_pct) begin
                    bus.in_valid = 1'b0;
                    bus.in_byte  = 8'($urandom);
                    @(posedge clk); #1;
                    if (bus.cpu_stall !== 1'b1) stall_bad++;
                end
                bus.in_valid = 1'b1;
                bus.in_byte  = stim[w][8*b +: 8];
                t = 0;
                while (bus.in_ready !== 1'b1 && t < 50) begin
                    @(posedge clk); #1;
                    t++;
                    if (bus.cpu_stall !== 1'b1) stall_bad++;
                end
                if (t >= 50) begin
                    checks++; errors++;
                    $display("FAIL handshake_timeout word %0d byte %0d in_ready=%0b want 1", w, b, bus.in_ready);
                    bus.in_valid = 1'b0;
                    return;
                end
                @(posedge clk); #1;
                sent++;
                if (bus.cpu_stall !== 1'b1) stall_bad++;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input int base, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (done_cnt > base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_load(input int n, input int gap_pct, output bit ok);
        int sent;
        int bd;
        bit dn;
        bd = done_cnt;
        pulse_start(n);
        send_bytes(n, gap_pct, n * 4, sent);
        wait_done(bd, dn);
        ok = dn && (sent == n * 4);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.num_words = '0; bus.in_byte = '0; bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.in_ready, bus.we, bus.waddr, bus.wdata, bus.cpu_stall, bus.done, bus.error} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%0b we=%0b a=%0d d=%h st=%0b dn=%0b er=%0b want all 0",
                     bus.in_ready, bus.we, bus.waddr, bus.wdata, bus.cpu_stall, bus.done, bus.error);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.cpu_stall !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got st=%0b rdy=%0b want 0 0", bus.cpu_stall, bus.in_ready);
        end
    endtask

    task automatic test_single_word();
        int bw, bd, bl;
        bit ok;
        stim[0] = 32'h00300413;
        bw = got_addr.size(); bd = done_cnt; bl = lat_bad;
        run_load(1, 0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_done_seen got 0 want 1"); end
        checks++;
        if (got_addr.size() - bw != 1) begin
            errors++; $display("FAIL single_we_count got %0d want 1", got_addr.size() - bw);
        end else begin
            checks++;
            if (got_addr[bw] !== 5'd0) begin errors++; $display("FAIL single_waddr got %0d want 0", got_addr[bw]); end
            checks++;
            if (got_data[bw] !== 32'h00300413) begin errors++; $display("FAIL single_wdata got %h want 00300413", got_data[bw]); end
        end
        checks++;
        if (done_cyc_last - we_cyc_last != 1) begin
            errors++; $display("FAIL single_done_latency got %0d want 1", done_cyc_last - we_cyc_last);
        end
        checks++;
        if (done_cnt - bd != 1) begin errors++; $display("FAIL single_done_pulses got %0d want 1", done_cnt - bd); end
        checks++;
        if (lat_bad != bl) begin errors++; $display("FAIL single_we_latency got %0d bad cycles want 0", lat_bad - bl); end
        checks++;
        if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL single_stall_after got %0b want 0", bus.cpu_stall); end
    endtask

    task automatic test_multi_gaps();
        int bw, bs, bl;
        bit ok;
        stim[0] = 32'h00300413; stim[1] = 32'h00100493; stim[2] = 32'h01000913;
        bw = got_addr.size(); bs = stall_bad; bl = lat_bad;
        run_load(3, 40, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL multi_done_seen got 0 want 1"); end
        checks++;
        if (got_addr.size() - bw != 3) begin
            errors++; $display("FAIL multi_we_count got %0d want 3", got_addr.size() - bw);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_addr[bw+i] !== AW'(i) || got_data[bw+i] !== stim[i]) begin
                    errors++;
                    $display("FAIL multi_write%0d got a=%0d d=%h want a=%0d d=%h", i, got_addr[bw+i], got_data[bw+i], i, stim[i]);
                end
            end
        end
        checks++;
        if (stall_bad != bs) begin errors++; $display("FAIL multi_stall_during got %0d low cycles want 0", stall_bad - bs); end
        checks++;
        if (lat_bad != bl) begin errors++; $display("FAIL multi_we_latency got %0d bad cycles want 0", lat_bad - bl); end
        checks++;
        if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL multi_stall_after got %0b want 0", bus.cpu_stall); end
    endtask

    task automatic test_errors();
        int bad_n[2] = '{0, 33};
        int bw, be;
        foreach (bad_n[k]) begin
            bw = got_addr.size(); be = err_cnt;
            pulse_start(bad_n[k]);
            checks++;
            if (bus.error !== 1'b1 || bus.cpu_stall !== 1'b0 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL error_pulse_n%0d got er=%0b st=%0b rdy=%0b want 1 0 0", bad_n[k], bus.error, bus.cpu_stall, bus.in_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (bus.error !== 1'b0 || bus.cpu_stall !== 1'b0) begin
                errors++; $display("FAIL error_one_cycle_n%0d got er=%0b st=%0b want 0 0", bad_n[k], bus.error, bus.cpu_stall);
            end
            repeat (3) @(posedge clk);
            #1;
            checks++;
            if (err_cnt - be != 1 || got_addr.size() != bw) begin
                errors++; $display("FAIL error_effects_n%0d got pulses=%0d writes=%0d want 1 0", bad_n[k], err_cnt - be, got_addr.size() - bw);
            end
        end
    endtask

    task automatic test_full_load();
        int bw;
        bit ok;
        for (int i = 0; i < 32; i++) stim[i] = $urandom;
        bw = got_addr.size();
        run_load(32, 15, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL full_done_seen got 0 want 1"); end
        checks++;
        if (got_addr.size() - bw != 32) begin
            errors++; $display("FAIL full_we_count got %0d want 32", got_addr.size() - bw);
        end else begin
            for (int i = 0; i < 32; i++) begin
                checks++;
                if (got_addr[bw+i] !== AW'(i) || got_data[bw+i] !== stim[i]) begin
                    errors++;
                    $display("FAIL full_write%0d got a=%0d d=%h want a=%0d d=%h", i, got_addr[bw+i], got_data[bw+i], i, stim[i]);
                end
            end
        end
    endtask

    task automatic test_reset_midload();
        int bw, sent;
        stim[0] = $urandom; stim[1] = $urandom;
        bw = got_addr.size();
        pulse_start(2);
        send_bytes(2, 0, 6, sent);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({bus.in_ready, bus.we, bus.waddr, bus.wdata, bus.cpu_stall, bus.done, bus.error} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs got rdy=%0b we=%0b a=%0d d=%h st=%0b dn=%0b er=%0b want all 0",
                     bus.in_ready, bus.we, bus.waddr, bus.wdata, bus.cpu_stall, bus.done, bus.error);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_byte  = 8'($urandom);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (got_addr.size() - bw != 1 || shadow[0] !== stim[0]) begin
            errors++; $display("FAIL midrst_writes got n=%0d mem0=%h want 1 %h", got_addr.size() - bw, shadow[0], stim[0]);
        end
        checks++;
        if (bus.in_ready !== 1'b0 || bus.cpu_stall !== 1'b0) begin
            errors++; $display("FAIL midrst_idle got rdy=%0b st=%0b want 0 0", bus.in_ready, bus.cpu_stall);
        end
    endtask

    task automatic test_start_ignored();
        int bw, bd, sent;
        bit dn;
        for (int i = 0; i < 3; i++) stim[i] = $urandom;
        bw = got_addr.size(); bd = done_cnt;
        fork
            begin
                pulse_start(3);
                send_bytes(3, 0, 12, sent);
                wait_done(bd, dn);
            end
            begin
                repeat (7) @(posedge clk);
                #1;
                bus.start     = 1'b1;
                bus.num_words = 6'd5;
                @(posedge clk); #1;
                bus.start     = 1'b0;
            end
        join
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (got_addr.size() - bw != 3 || done_cnt - bd != 1) begin
            errors++; $display("FAIL restart_ignored got writes=%0d dones=%0d want 3 1", got_addr.size() - bw, done_cnt - bd);
        end
        checks++;
        if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL restart_stall_after got %0b want 0", bus.cpu_stall); end
    endtask

    task automatic test_random_loads();
        int n, bw;
        bit ok;
        for (int r = 0; r < 5; r++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) stim[i] = $urandom;
            bw = got_addr.size();
            run_load(n, 30, ok);
            checks++;
            if (!ok || got_addr.size() - bw != n) begin
                errors++; $display("FAIL rand%0d_count got writes=%0d done=%0b want %0d 1", r, got_addr.size() - bw, ok, n);
            end else begin
                for (int i = 0; i < n; i++) begin
                    checks++;
                    if (got_addr[bw+i] !== AW'(i) || got_data[bw+i] !== stim[i]) begin
                        errors++;
                        $display("FAIL rand%0d_write%0d got a=%0d d=%h want a=%0d d=%h", r, i, got_addr[bw+i], got_data[bw+i], i, stim[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.num_words = '0; bus.in_byte = '0; bus.in_valid = 1'b0;
        test_reset();
        test_single_word();
        test_multi_gaps();
        test_errors();
        test_full_load();
        test_reset_midload();
        test_start_ignored();
        test_random_loads();
        checks++;
        if (lat_bad != 0) begin errors++; $display("FAIL we_latency_overall got %0d bad cycles want 0", lat_bad); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, instruction-memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, instruction word width; byte lanes = DATA_W/8 = 4.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  begin a load; sampled only in IDLE.
REQ-006 SHALL have port num_words  input  ADDR_W+1  words to load, legal 1..32, sampled with start.
REQ-007 SHALL have port in_byte  input  8  program byte stream, little-endian per word.
REQ-008 SHALL have port in_valid  input  1  in_byte valid.
REQ-009 SHALL have port in_ready  output  1  loader accepts byte; a transfer occurs when in_valid and in_ready are both high.
REQ-010 SHALL have port we  output  1  instruction-memory write enable, one-cycle pulse per word.
REQ-011 SHALL have port waddr  output  ADDR_W  word address written.
REQ-012 SHALL have port wdata  output  DATA_W  word written.
REQ-013 SHALL have port cpu_stall  output  1  holds the core's PC while a load is in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse on successful completion.
REQ-015 SHALL have port error  output  1  one-cycle pulse on an illegal num_words at start.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, WRITE, DONE.
REQ-017 IDLE: in_ready=0, we=0, cpu_stall=0; start with num_words in 1..32 -> LOAD, word counter=0, byte index=0.
REQ-018 IDLE: start with num_words=0 or >32 -> error=1 next cycle, state stays IDLE, no write.
REQ-019 LOAD: in_ready=1; each transfer places in_byte in lane byte_index (byte 0 -> bits 7:0), byte_index increments.
REQ-020 LOAD: transfer of lane 3 -> WRITE next cycle; in_valid low holds state and the assembly register unchanged.
REQ-021 WRITE: in_ready=0, we=1 for exactly one cycle, waddr=word counter, wdata=assembled word; then word counter increments.
REQ-022 WRITE: if the word just written is number num_words -> DONE; otherwise -> LOAD with byte_index=0.
REQ-023 DONE: done=1 for one cycle, then -> IDLE.
REQ-024 cpu_stall SHALL be 1 in LOAD, WRITE and DONE, and 0 only in IDLE.
REQ-025 start while not in IDLE SHALL be ignored; num_words is latched at start and is not re-sampled.
REQ-026 Latency: we asserts exactly one cycle after the 4th byte transfer of a word.
REQ-027 Word counter SHALL never exceed 31 when writing; num_words=32 ends at waddr=31 with no wrap.
REQ-028 in_valid asserted outside LOAD SHALL have no effect (bytes not consumed).

Reset
REQ-029 rst SHALL force IDLE, in_ready=0, we=0, waddr=0, wdata=0, cpu_stall=0, done=0, error=0, counters=0 on the next edge.
REQ-030 rst mid-load SHALL discard the partial word; words already written stay in memory (loader issues no clearing writes).

Structure
REQ-031 FSM state encoding, ADDR_W/DATA_W defaults and the max-word constant 32 SHALL live in a shared package.
REQ-032 Block SHALL be a single module; no sub-module is required; an optional wrapper pairs it with a writable instruction memory.

Verification
REQ-033 start, num_words=1, bytes 13 04 30 00 -> one we pulse, waddr=0, wdata=0x00300413, done one cycle after the WRITE cycle.
REQ-034 num_words=3, bytes for 0x00300413, 0x00100493, 0x01000913 with in_valid gaps -> three we pulses at waddr 0,1,2 with matching wdata; cpu_stall high throughout, low after done.
REQ-035 num_words=0 and num_words=33 -> error pulse, no we, cpu_stall stays 0.
REQ-036 num_words=32 full load -> last write at waddr=31, exactly 32 we pulses, no write to address 0 after the first.
REQ-037 rst asserted after 2 bytes of word 1 in a 2-word load -> all outputs 0 next cycle, word 0 remains written, no further we.
REQ-038 start pulsed again mid-load with num_words=5 -> ignored; load completes with the original count.
